haski_mem_ctrl: RTL and testbench

//   Memory-side controller directly downstream of the CPU core. Consumes the core's 95-bit
//   RAM request bus and drives a single-port, variable-latency memory through an en/ready

---
 rtl/haski_mem_ctrl.sv | 132 +++++++++++++
 tb/tb_haski_mem_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/haski_mem_ctrl.sv
// Memory-side controller: core RAM request bus to en/ready memory port.
// Bounded wait with timeout abort, sticky error flag, one-cycle ack.
module haski_mem_ctrl #(
  parameter int ADDR_W  = 29,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                     system1000,
  input  logic                     system1000_rst,
  input  logic [ADDR_W+DATA_W+1:0] req_i,
  input  logic                     running_i,
  output logic [DATA_W:0]          status_o,
  output logic                     mem_en_o,
  output logic                     mem_we_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [DATA_W-1:0]        mem_wdata_o,
  input  logic [DATA_W-1:0]        mem_rdata_i,
  input  logic                     mem_ready_i,
  output logic                     err_o
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              en_d, we_d, err_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic [DATA_W:0]   status_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign op        = req_i[ADDR_W+DATA_W+1 -: 2];
  assign req_addr  = req_i[ADDR_W+DATA_W-1 -: ADDR_W];
  assign req_wdata = req_i[DATA_W-1:0];

  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    en_d     = mem_en_o;
    we_d     = mem_we_o;
    addr_d   = mem_addr_o;
    wdata_d  = mem_wdata_o;
    status_d = '0;
    err_d    = err_o;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (running_i) begin
          unique case (op)
            2'b01, 2'b10: begin
              state_d = ACCESS;
              en_d    = 1'b1;
              we_d    = (op == 2'b10);
              addr_d  = req_addr;
              wdata_d = req_wdata;
              cnt_d   = '0;
            end
            2'b11: begin
              state_d  = RESP;
              status_d = {1'b1, {DATA_W{1'b0}}};
              err_d    = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        // ready takes priority over a coincident timeout
        if (mem_ready_i) begin
          state_d  = RESP;
          en_d     = 1'b0;
          we_d     = 1'b0;
          status_d = {1'b1, mem_we_o ? {DATA_W{1'b0}} : mem_rdata_i};
        end else if (cnt_q == CNT_LAST) begin
          state_d  = RESP;
          en_d     = 1'b0;
          we_d     = 1'b0;
          status_d = {1'b1, {DATA_W{1'b0}}};
          err_d    = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      status_o    <= '0;
      err_o       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      mem_en_o    <= en_d;
      mem_we_o    <= we_d;
      mem_addr_o  <= addr_d;
      mem_wdata_o <= wdata_d;
      status_o    <= status_d;
      err_o       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_haski_mem_ctrl.sv
// Bench for haski_mem_ctrl: vector table, directed corner cases,
// and random traffic against a transaction-level reference model.
module tb_haski_mem_ctrl;

  localparam int AW = 29;
  localparam int DW = 64;
  localparam int TO = 8;

  logic          system1000;
  logic          system1000_rst;
  logic [94:0]   req;
  logic          running;
  logic [DW:0]   status;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          err;

  int checks = 0;
  int errors = 0;

  haski_mem_ctrl #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .system1000    (system1000),
    .system1000_rst(system1000_rst),
    .req_i         (req),
    .running_i     (running),
    .status_o      (status),
    .mem_en_o      (mem_en),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_rdata_i   (mem_rdata),
    .mem_ready_i   (mem_ready),
    .err_o         (err)
  );

  initial begin
    system1000 = 1'b0;
    forever #5 system1000 = ~system1000;
  end

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          run;
    logic          rdy;
    logic [DW-1:0] rd;
    logic          e_en;
    logic          e_we;
    logic          e_ack;
    logic [DW-1:0] e_data;
    logic          e_err;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d;
  } vec_t;

  vec_t tv[20];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic e_en,
                         input logic e_we, input logic e_ack,
                         input logic [DW-1:0] e_data, input logic e_err);
    chk(nm, {60'd0, mem_en, mem_we, status, err},
        {60'd0, e_en, e_we, e_ack, e_data, e_err});
  endtask

  task automatic drive(input logic [1:0] op, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic run,
                       input logic rdy, input logic [DW-1:0] rd);
    req       = {op, a, d};
    running   = run;
    mem_ready = rdy;
    mem_rdata = rd;
  endtask

  task automatic step(input logic [1:0] op, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic run,
                      input logic rdy, input logic [DW-1:0] rd);
    drive(op, a, d, run, rdy, rd);
    @(posedge system1000);
    @(negedge system1000);
  endtask

  task automatic idle(input logic rdy);
    step(2'b00, '0, '0, 1'b1, rdy, '0);
  endtask

  task automatic do_reset();
    system1000_rst = 1'b1;
    drive(2'b00, '0, '0, 1'b0, 1'b0, '0);
    @(posedge system1000);
    @(posedge system1000);
    @(negedge system1000);
    chk_out("reset", 0, 0, 0, '0, 0);
    chk("reset_addr", {35'd0, mem_addr, mem_wdata}, '0);
    system1000_rst = 1'b0;
  endtask

  // reference model: one outstanding transaction, described by its
  // progress rather than by controller states
  logic          m_busy, m_we, m_resp, m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  int            m_wait;

  task automatic model_clear();
    m_busy = 0; m_we = 0; m_resp = 0; m_err = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_wait = 0;
  endtask

  task automatic model_step();
    logic [1:0] op;
    op = req[94:93];
    if (m_resp) begin
      m_resp = 0;
    end else if (m_busy) begin
      if (mem_ready) begin
        m_busy  = 0;
        m_resp  = 1;
        m_rdata = m_we ? '0 : mem_rdata;
      end else if (m_wait == TO - 1) begin
        m_busy  = 0;
        m_resp  = 1;
        m_rdata = '0;
        m_err   = 1;
      end else begin
        m_wait++;
      end
    end else if (running && op != 2'b00) begin
      if (op == 2'b11) begin
        m_resp  = 1;
        m_rdata = '0;
        m_err   = 1;
      end else begin
        m_busy  = 1;
        m_we    = (op == 2'b10);
        m_addr  = req[92:64];
        m_wdata = req[63:0];
        m_wait  = 0;
      end
    end
  endtask

  initial begin
    logic [DW-1:0] rd;
    int r;
    system1000_rst = 1'b1;
    drive(2'b00, '0, '0, 1'b0, 1'b0, '0);

    tv[0]  = '{2'b01, 29'h10, 64'h0, 1, 0, 64'h0,
               1, 0, 0, 64'h0, 0, 29'h10, 64'h0};
    tv[1]  = '{2'b00, 29'h0, 64'h0, 1, 1, 64'hDEADBEEF01234567,
               0, 0, 1, 64'hDEADBEEF01234567, 0, 29'h0, 64'h0};
    tv[2]  = '{2'b00, 29'h0, 64'h0, 1, 0, 64'h0,
               0, 0, 0, 64'h0, 0, 29'h0, 64'h0};
    for (int i = 3; i < 8; i++)
      tv[i] = '{2'b01, 29'h33, 64'h7, 0, 0, 64'h0,
                0, 0, 0, 64'h0, 0, 29'h0, 64'h0};
    tv[8]  = '{2'b10, 29'h1FFFFFFF, 64'hA5A5A5A5A5A5A5A5, 1, 0, 64'h0,
               1, 1, 0, 64'h0, 0, 29'h1FFFFFFF, 64'hA5A5A5A5A5A5A5A5};
    for (int i = 9; i < 12; i++)
      tv[i] = '{2'b01, 29'h44, 64'h1, 1, 0, 64'h0,
                1, 1, 0, 64'h0, 0, 29'h1FFFFFFF, 64'hA5A5A5A5A5A5A5A5};
    tv[12] = '{2'b00, 29'h0, 64'h0, 1, 1, 64'h5555,
               0, 0, 1, 64'h0, 0, 29'h0, 64'h0};
    tv[13] = '{2'b00, 29'h0, 64'h0, 1, 0, 64'h0,
               0, 0, 0, 64'h0, 0, 29'h0, 64'h0};
    tv[14] = '{2'b01, 29'h5, 64'h0, 1, 0, 64'h0,
               1, 0, 0, 64'h0, 0, 29'h5, 64'h0};
    tv[15] = '{2'b00, 29'h0, 64'h0, 0, 0, 64'h0,
               1, 0, 0, 64'h0, 0, 29'h5, 64'h0};
    tv[16] = '{2'b00, 29'h0, 64'h0, 0, 1, 64'h1234,
               0, 0, 1, 64'h1234, 0, 29'h0, 64'h0};
    tv[17] = '{2'b00, 29'h0, 64'h0, 0, 1, 64'hFFFF,
               0, 0, 0, 64'h0, 0, 29'h0, 64'h0};
    tv[18] = '{2'b11, 29'h9, 64'h9, 1, 0, 64'h0,
               0, 0, 1, 64'h0, 1, 29'h0, 64'h0};
    tv[19] = '{2'b00, 29'h0, 64'h0, 1, 0, 64'h0,
               0, 0, 0, 64'h0, 1, 29'h0, 64'h0};

    @(negedge system1000);
    do_reset();

    for (int i = 0; i < 20; i++) begin
      step(tv[i].op, tv[i].a, tv[i].d, tv[i].run, tv[i].rdy, tv[i].rd);
      chk_out($sformatf("vec%0d", i), tv[i].e_en, tv[i].e_we,
              tv[i].e_ack, tv[i].e_data, tv[i].e_err);
      if (tv[i].e_en)
        chk($sformatf("vec%0d_addr", i), {35'd0, mem_addr, mem_wdata},
            {35'd0, tv[i].e_a, tv[i].e_d});
    end

    // timeout: en held TO cycles, aborted ack, sticky err
    do_reset();
    step(2'b01, 29'h22, '0, 1, 0, '0);
    chk_out("to_en0", 1, 0, 0, '0, 0);
    for (int i = 1; i < TO; i++) begin
      idle(1'b0);
      chk_out($sformatf("to_en%0d", i), 1, 0, 0, '0, 0);
    end
    idle(1'b0);
    chk_out("to_ack", 0, 0, 1, '0, 1);
    idle(1'b0);
    chk_out("to_after", 0, 0, 0, '0, 1);
    step(2'b01, 29'h23, '0, 1, 0, '0);
    step(2'b00, '0, '0, 1, 1, 64'hCAFE);
    chk_out("to_sticky", 0, 0, 1, 64'hCAFE, 1);

    // ready in the last allowed cycle wins over timeout
    do_reset();
    step(2'b01, 29'h24, '0, 1, 0, '0);
    for (int i = 1; i < TO; i++) idle(1'b0);
    chk_out("last_en", 1, 0, 0, '0, 0);
    step(2'b00, '0, '0, 1, 1, 64'hBEEF0000BEEF);
    chk_out("last_ack", 0, 0, 1, 64'hBEEF0000BEEF, 0);

    // reset mid-access aborts at once, no stale ack afterwards
    do_reset();
    step(2'b11, '0, '0, 1, 0, '0);
    idle(1'b0);
    step(2'b01, 29'h30, '0, 1, 0, '0);
    chk_out("rst_pre", 1, 0, 0, '0, 1);
    system1000_rst = 1'b1;
    #1;
    chk_out("rst_async", 0, 0, 0, '0, 0);
    @(posedge system1000);
    @(negedge system1000);
    system1000_rst = 1'b0;
    idle(1'b1);
    chk_out("rst_nostale", 0, 0, 0, '0, 0);
    step(2'b01, 29'h31, '0, 1, 0, '0);
    step(2'b00, '0, '0, 1, 1, 64'h77);
    chk_out("rst_resume", 0, 0, 1, 64'h77, 0);

    // random traffic against the reference model
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      model_clear();
      for (int c = 0; c < 200; c++) begin
        r  = $urandom_range(0, 19);
        rd = {$urandom, $urandom};
        drive(r < 6 ? 2'b00 : r < 12 ? 2'b01 : r < 19 ? 2'b10 : 2'b11,
              AW'($urandom), {$urandom, $urandom},
              $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0, rd);
        @(posedge system1000);
        model_step();
        @(negedge system1000);
        chk_out($sformatf("rand%0d_%0d", seg, c), m_busy, m_busy & m_we,
                m_resp, m_resp ? m_rdata : '0, m_err);
        if (m_busy)
          chk($sformatf("rand%0d_%0d_addr", seg, c),
              {35'd0, mem_addr, mem_wdata}, {35'd0, m_addr, m_wdata});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
